// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the accepted-operation decode.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WR    = 2'd1,
        OP_RD    = 2'd2,
        OP_WR_RD = 2'd3
    } fifo_op_t;

endpackage

// File: rtl/reg_file.sv
// Storage array for the FIFO: synchronous write, combinational read so the head
// word falls through with zero latency. Contents are never reset.
module reg_file
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

    // Word write on accepted enqueue.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_r[w_addr] <= w_data;
        end else begin
            mem_r[w_addr] <= mem_r[w_addr];
        end
    end

    assign r_data = mem_r[r_addr];

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller driving an external reg_file, with
// registered status flags and sticky overflow/underflow reporting.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [ADDR_WIDTH:0]   count_r, count_nxt_s;
    logic                  full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
    logic                  ovf_nxt_s, udf_nxt_s;
    logic                  wr_acc_s, rd_acc_s;
    fifo_op_t              op_s;

    // Accept decode and next-state computation for pointers, count and sticky flags.
    always_comb begin
        // A write into a full queue is legal when a simultaneous pop frees the slot.
        wr_acc_s = wr & (~full_r | rd) & ~flush & ~reset;
        rd_acc_s = rd & ~empty_r & ~flush & ~reset;

        if (wr_acc_s && rd_acc_s) begin
            op_s = OP_WR_RD;
        end else if (wr_acc_s) begin
            op_s = OP_WR;
        end else if (rd_acc_s) begin
            op_s = OP_RD;
        end else begin
            op_s = OP_NOP;
        end

        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
            rd_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
            count_nxt_s  = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            case (op_s)
                OP_WR: begin
                    wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                    count_nxt_s  = count_r + CNT_ONE;
                end
                OP_RD: begin
                    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                    count_nxt_s  = count_r - CNT_ONE;
                end
                OP_WR_RD: begin
                    wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end

        // A fresh error event wins over err_clr in the same cycle.
        ovf_nxt_s = (wr & full_r & ~rd & ~flush) ? 1'b1 : (err_clr ? 1'b0 : ovf_r);
        udf_nxt_s = (rd & empty_r & ~flush)      ? 1'b1 : (err_clr ? 1'b0 : udf_r);
    end

    // State and registered status flags; reset dominates every other control.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= {(ADDR_WIDTH+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == {(ADDR_WIDTH+1){1'b0}});
            af_r     <= (count_nxt_s >= AF_C);
            ae_r     <= (count_nxt_s <= AE_C);
            ovf_r    <= ovf_nxt_s;
            udf_r    <= udf_nxt_s;
        end
    end

    assign w_en         = wr_acc_s;
    assign w_addr       = wr_ptr_r;
    assign r_addr       = rd_ptr_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench: fifo_ctrl wired to reg_file as in the top-level fifo, with
// hand-computed expectations checked by immediate assertions.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset, wr, rd, flush, err_clr;
    logic       w_en, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] w_addr, r_addr;
    logic [3:0] count;
    logic [7:0] w_data, r_data;

    int vectors = 0;
    int errors  = 0;

    fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .flush(flush), .err_clr(err_clr),
        .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    reg_file #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) mem (
        .clk(clk), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_addr(r_addr), .r_data(r_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of controls; leaves time to settle before pre-edge checks.
    task automatic drive(input logic rs, input logic w, input logic r, input logic f,
                         input logic ec, input logic [7:0] d);
        reset = rs; wr = w; rd = r; flush = f; err_clr = ec; w_data = d;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_ae"}, 32'(almost_empty), 32'd1);
        check({tag, "_af"}, 32'(almost_full), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_udf"}, 32'(underflow), 32'd0);
        check({tag, "_waddr"}, 32'(w_addr), 32'd0);
        check({tag, "_raddr"}, 32'(r_addr), 32'd0);
    endtask

    initial begin
        logic [7:0] drain_exp [8];
        drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};

        // Reset with wr/rd active: reset gates w_en and dominates.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_wen", 32'(w_en), 32'd0);
        tick();
        tick();
        check_reset_state("rst");

        // Fill with 0x10..0x17.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
            check("fill_wen", 32'(w_en), 32'd1);
            check("fill_waddr", 32'(w_addr), 32'(i));
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 6));
            check("fill_full", 32'(full), 32'(i == 7));
            check("fill_empty", 32'(empty), 32'd0);
        end
        check("full_waddr_wrap", 32'(w_addr), 32'd0);
        check("full_ovf", 32'(overflow), 32'd0);
        check("full_head", 32'(r_data), 32'h10);

        // Write while full, no read: refused, overflow sets.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        check("ovf_wen", 32'(w_en), 32'd0);
        tick();
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        // New overflow event beats err_clr in the same cycle.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        tick();
        check("ovf_prio", 32'(overflow), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("ovf_clr", 32'(overflow), 32'd0);
        check("ovf_clr_head", 32'(r_data), 32'h10);

        // Full with wr=rd: both accepted, 0x20 lands at address 0.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        check("wrrd_full_wen", 32'(w_en), 32'd1);
        check("wrrd_full_waddr", 32'(w_addr), 32'd0);
        check("wrrd_full_head", 32'(r_data), 32'h10);
        tick();
        check("wrrd_full_count", 32'(count), 32'd8);
        check("wrrd_full_full", 32'(full), 32'd1);
        check("wrrd_full_ovf", 32'(overflow), 32'd0);
        check("wrrd_full_raddr", 32'(r_addr), 32'd1);

        // Drain all eight.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            check("drain_data", 32'(r_data), 32'(drain_exp[k]));
            tick();
            check("drain_count", 32'(count), 32'(7 - k));
            check("drain_ae", 32'(almost_empty), 32'((7 - k) <= 1));
            check("drain_empty", 32'(empty), 32'(k == 7));
        end
        check("drain_udf", 32'(underflow), 32'd0);

        // Read while empty.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_count", 32'(count), 32'd0);

        // wr=rd while empty: only the write is taken.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
        check("wrrd_empty_wen", 32'(w_en), 32'd1);
        tick();
        check("wrrd_empty_count", 32'(count), 32'd1);
        check("wrrd_empty_udf", 32'(underflow), 32'd1);
        check("wrrd_empty_empty", 32'(empty), 32'd0);
        check("wrrd_empty_head", 32'(r_data), 32'h30);

        // Build count 5, then flush with wr=1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h31 + i));
            tick();
        end
        check("pre_flush_count", 32'(count), 32'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
        check("flush_wen", 32'(w_en), 32'd0);
        tick();
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_full", 32'(full), 32'd0);
        check("flush_waddr", 32'(w_addr), 32'd0);
        check("flush_raddr", 32'(r_addr), 32'd0);
        check("flush_udf_kept", 32'(underflow), 32'd1);
        check("flush_ovf_kept", 32'(overflow), 32'd0);

        // Clear, then flush with rd on an empty queue must not set underflow.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("udf_clr", 32'(underflow), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        check("flush_rd_udf", 32'(underflow), 32'd0);

        // Set underflow, load four words, then reset mid-operation.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
            tick();
        end
        check("pre_rst_count", 32'(count), 32'd4);
        check("pre_rst_udf", 32'(underflow), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        check("rst2_wen", 32'(w_en), 32'd0);
        tick();
        check_reset_state("rst2");
        check("rst2_wen_after", 32'(w_en), 32'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
